fft_pair_feeder: RTL and testbench
==================================

// Module: fft_pair_feeder
// PURPOSE
// Input-side frame buffer for the 2-point butterfly (com_2pt). Accepts a serial stream of
// complex samples, one per cycle. Collects each N-sample frame into a ping-pong buffer.
// Emits N/2 butterfly operand pairs (x[i], x[i+N/2]), one pair per cycle, on ports that
// wire directly to xin_real0/1 and xin_imag0/1 of com_2pt.
// PARAMETERS
// N   8   frame length; power of two, >= 2
// DW  32  sample width per component, signed two's complement
// PORTS
// clk         in   1   clock; all state changes on rising edge
// rst         in   1   reset, asynchronous, active-high
// in_valid    in   1   in_real/in_imag carry a sample
// in_ready    out  1   block accepts a sample this cycle
// in_real     in   DW  sample real part, signed
// in_imag     in   DW  sample imag part, signed
// out_valid   out  1   pair outputs valid
// out_ready   in   1   consumer takes the pair; tie 1 when feeding com_2pt directly
// pair_real0  out  DW  x[i] real
// pair_real1  out  DW  x[i+N/2] real
// pair_imag0  out  DW  x[i] imag
// pair_imag1  out  DW  x[i+N/2] imag
// pair_last   out  1   high with the final pair (i = N/2-1) of a frame
// BEHAVIOUR
// - Storage: 2 banks x N entries x 2*DW bits, held in flops. Per-bank full flag.
//   Write side: wr_bank, wr_cnt (0..N-1). Read side: rd_bank, rd_cnt (0..N/2-1).
// - Reset: pointers, banks and full flags go to 0. in_ready=1, out_valid=0, pair_last=0,
//   pair_* = 0. Buffer contents need not be cleared.
// - in_ready = !full[wr_bank]. It is a registered flag, with no combinational path from
//   out_ready.
// - Accept = in_valid & in_ready: write bank[wr_bank][wr_cnt], then wr_cnt++.
//   On the accept at wr_cnt==N-1: set full[wr_bank], toggle wr_bank, clear wr_cnt.
// - in_valid gaps are allowed anywhere. A partial frame simply waits.
// - out_valid = full[rd_bank].
//   pair_*0 = bank[rd_bank][rd_cnt]; pair_*1 = bank[rd_bank][rd_cnt+N/2].
//   Both are combinational from the flops. All pair_* outputs are forced to 0 when
//   out_valid=0.
// - pair_last = out_valid & (rd_cnt==N/2-1).
// - Pop = out_valid & out_ready: rd_cnt++. On the pop with pair_last set: clear
//   full[rd_bank], toggle rd_bank, clear rd_cnt.
// - Latency: the accept of sample N-1 at edge t gives out_valid=1 after edge t, so the
//   first pair is visible in the next cycle. com_2pt adds 1 further cycle.
// - Throughput: with out_ready=1, continuous input never deasserts in_ready. A bank
//   drains in N/2 cycles and refills in N.
// - Simultaneous pop-to-free on one bank and accept on the other: both take effect.
//   A bank freed at edge t accepts data from cycle t+1 on.
// - Both banks full: in_ready=0 and the input sample is held by the source. No data loss
//   and no overwrite.
// - Data is passed bit-exact: no arithmetic and no saturation.
//   Extremes 0x80000000 and 0x7FFFFFFF are passed unchanged.
// - Reset mid-operation discards any partial or unread frame.
//   The first accept after reset is sample 0 of a new frame.
// TESTING
// 1 Reset asserted mid-cycle (async) -> in_ready=1, out_valid=0, pair_*=0 immediately.
// 2 N=8, out_ready=1, samples real=k, imag=-k for k=0..7 ->
//   pairs (0,4),(1,5),(2,6),(3,7) with imag negated. out_valid rises the cycle after
//   the 8th accept. pair_last is high on the 4th pair only.
// 3 Three back-to-back frames (24 consecutive accepts), out_ready=1 -> in_ready stays 1
//   throughout. 12 pairs come out in frame order with no gaps inside a frame.
// 4 out_ready=0 from the start -> after 16 accepts in_ready=0, and sample 17 is held
//   while in_ready=0. Set out_ready=1 -> frame-0 pairs emerge, in_ready=1 one cycle
//   after frame 0's last pop, then sample 17 is accepted intact.
// 5 in_valid toggling 1,0,1,0 with samples 0x7FFFFFFF/0x80000000 alternating ->
//   pairs bit-exact, no samples dropped or duplicated.
// 6 Assert rst after 5 accepts, release, send a full frame k=100..107 -> pairs
//   (100,104)..(103,107). No remnant of the aborted frame appears.

Source files
------------

// File: rtl/fft_pair_feeder.sv
// Ping-pong frame buffer feeding a 2-point butterfly: collects N serial complex samples
// per bank, then presents (x[i], x[i+N/2]) pairs one per cycle.
module fft_pair_feeder #(
    parameter int N  = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] pair_real0,
    output logic [DW-1:0] pair_real1,
    output logic [DW-1:0] pair_imag0,
    output logic [DW-1:0] pair_imag1,
    output logic          pair_last
);
    localparam int H  = N / 2;
    localparam int AW = (N > 2) ? $clog2(N) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } sample_t;

    sample_t [1:0][N-1:0] mem;
    logic    [1:0]        full;
    logic                 wr_bank, rd_bank;
    logic    [AW-1:0]     wr_cnt;
    logic    [RW-1:0]     rd_cnt;

    logic    acc, acc_last, pop, pop_last;
    logic    [AW-1:0] idx0, idx1;
    sample_t s0, s1;

    assign in_ready  = ~full[wr_bank];
    assign out_valid = full[rd_bank];
    assign pair_last = out_valid & (rd_cnt == RW'(H - 1));

    assign acc      = in_valid & in_ready;
    assign acc_last = acc & (wr_cnt == AW'(N - 1));
    assign pop      = out_valid & out_ready;
    assign pop_last = pop & pair_last;

    // Control state; set and clear of full[] always target different banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            if (acc) begin
                wr_cnt <= acc_last ? '0 : wr_cnt + AW'(1);
                if (acc_last) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (pop) begin
                rd_cnt <= pop_last ? '0 : rd_cnt + RW'(1);
                if (pop_last) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end

    // Sample storage carries no reset; full[] guards every read.
    always_ff @(posedge clk) begin
        if (acc)
            mem[wr_bank][wr_cnt] <= {in_real, in_imag};
    end

    assign idx0 = AW'(rd_cnt);
    assign idx1 = idx0 + AW'(H);
    assign s0   = mem[rd_bank][idx0];
    assign s1   = mem[rd_bank][idx1];

    assign pair_real0 = out_valid ? s0.re : '0;
    assign pair_imag0 = out_valid ? s0.im : '0;
    assign pair_real1 = out_valid ? s1.re : '0;
    assign pair_imag1 = out_valid ? s1.im : '0;

endmodule

// File: tb/tb_fft_pair_feeder.sv
// Directed + random bench for fft_pair_feeder against a frame-level reference model
// built from accept/pop counts and an in-order history of accepted samples.
module tb_fft_pair_feeder;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int H  = N / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, pair_last;
    logic [DW-1:0] in_real, in_imag;
    logic [DW-1:0] pair_real0, pair_real1, pair_imag0, pair_imag1;

    fft_pair_feeder #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .pair_real0(pair_real0), .pair_real1(pair_real1),
        .pair_imag0(pair_imag0), .pair_imag1(pair_imag1),
        .pair_last(pair_last)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: every accepted sample in order, plus accept/pop counts since reset.
    logic [2*DW-1:0] hist[$];
    int nacc, npop;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        nacc = 0;
        npop = 0;
    endtask

    // One clock: drive, check outputs at negedge against the model, then advance the model.
    task automatic step(input logic iv, input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input logic ordy, output logic acc);
        int fd, fr, i, base;
        logic ev, er, pop;
        logic [DW-1:0] r0, r1, m0, m1;
        in_valid = iv; in_real = re; in_imag = im; out_ready = ordy;
        @(negedge clk);
        fd = nacc / N;
        fr = npop / H;
        ev = fd > fr;
        er = (fd - fr) < 2;
        i  = npop % H;
        r0 = '0; r1 = '0; m0 = '0; m1 = '0;
        if (ev) begin
            base = fr * N + i;
            r0 = hist[base][2*DW-1:DW];
            m0 = hist[base][DW-1:0];
            r1 = hist[base+H][2*DW-1:DW];
            m1 = hist[base+H][DW-1:0];
        end
        chk("in_ready", DW'(in_ready), DW'(er));
        chk("out_valid", DW'(out_valid), DW'(ev));
        chk("pair_last", DW'(pair_last), DW'(ev && i == H - 1));
        chk("pair_real0", pair_real0, r0);
        chk("pair_real1", pair_real1, r1);
        chk("pair_imag0", pair_imag0, m0);
        chk("pair_imag1", pair_imag1, m1);
        acc = iv & er;
        pop = ev & ordy;
        @(posedge clk);
        if (acc) begin
            hist.push_back({re, im});
            nacc++;
        end
        if (pop) npop++;
        #1;
    endtask

    // Present one sample until accepted, bounded.
    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic ordy);
        logic a;
        a = 1'b0;
        for (int t = 0; t < 40 && !a; t++) step(1'b1, re, im, ordy, a);
        if (!a) begin
            n_assert++;
            n_fail++;
            $error("FAIL send_timeout observed=stalled expected=accept");
        end
    endtask

    task automatic idle(input int cycles, input logic ordy);
        logic a;
        for (int t = 0; t < cycles; t++) step(1'b0, $urandom, $urandom, ordy, a);
    endtask

    // Async reset raised mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_pair_last", DW'(pair_last), DW'(0));
        chk("rst_real0", pair_real0, '0);
        chk("rst_real1", pair_real1, '0);
        chk("rst_imag0", pair_imag0, '0);
        chk("rst_imag1", pair_imag1, '0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic a;
        int   cyc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_real = '0; in_imag = '0;
        model_clear();
        #1;
        chk("init_in_ready", DW'(in_ready), DW'(1));
        chk("init_out_valid", DW'(out_valid), DW'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single frame k, -k
        for (int k = 0; k < N; k++) send(DW'(k), -DW'(k), 1'b1);
        chk("t2_valid_after_last", DW'(out_valid), DW'(1));
        chk("t2_first_real0", pair_real0, DW'(0));
        chk("t2_first_real1", pair_real1, DW'(4));
        chk("t2_first_imag1", pair_imag1, -DW'(4));
        idle(6, 1'b1);
        chk("t2_pairs", DW'(npop), DW'(H));

        // Three back-to-back frames, never stalled
        for (int k = 0; k < 3 * N; k++) begin
            step(1'b1, DW'(1000 + k), DW'($urandom), 1'b1, a);
            chk("t3_accept", DW'(a), DW'(1));
        end
        idle(6, 1'b1);

        // Mid-operation async reset with a full frame and a partial one pending
        for (int k = 0; k < N + 3; k++) send(DW'($urandom), DW'($urandom), 1'b0);
        do_reset();

        // Backpressure: both banks fill, sample 17 held
        for (int k = 0; k < 2 * N; k++) send(DW'(200 + k), DW'(300 + k), 1'b0);
        for (int t = 0; t < 3; t++) begin
            step(1'b1, DW'(216), DW'(316), 1'b0, a);
            chk("t4_held", DW'(a), DW'(0));
        end
        a = 1'b0;
        cyc = 0;
        while (!a && cyc < 20) begin
            step(1'b1, DW'(216), DW'(316), 1'b1, a);
            cyc++;
        end
        chk("t4_accept_cycle", DW'(cyc), DW'(H + 1));
        idle(8, 1'b1);
        chk("t4_pops", DW'(npop), DW'(2 * H));
        do_reset();

        // Extremes with in_valid gaps
        for (int k = 0; k < 2 * N; k++) begin
            step(1'b1, k[0] ? 32'h8000_0000 : 32'h7FFF_FFFF,
                       k[0] ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b1, a);
            chk("t5_accept", DW'(a), DW'(1));
            step(1'b0, $urandom, $urandom, 1'b1, a);
        end
        idle(6, 1'b1);
        chk("t5_pops", DW'(npop), DW'(2 * H));

        // Random traffic
        for (int t = 0; t < 400; t++)
            step(1'(($urandom % 3) != 0), $urandom, $urandom, 1'(($urandom % 4) != 0), a);
        idle(12, 1'b1);

        // Abort after 5 accepts, then a clean frame
        do_reset();
        for (int k = 0; k < 5; k++) send(DW'(50 + k), DW'(60 + k), 1'b1);
        do_reset();
        for (int k = 0; k < N; k++) send(DW'(100 + k), DW'(-(100 + k)), 1'b1);
        chk("t6_real0", pair_real0, DW'(100));
        chk("t6_real1", pair_real1, DW'(104));
        idle(6, 1'b1);
        chk("t6_pops", DW'(npop), DW'(H));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
